// File: rtl/dc_lseq_pkg.sv
// Shared types for the line sequencer.
//   lseq_state_e : request FSM states
//   acc_width()  : width of the DDA accumulator for a given line-count width
package dc_lseq_pkg;

    typedef enum logic [1:0] {
        StIdle      = 2'd0,
        StWaitSpace = 2'd1,
        StRequest   = 2'd2,
        StStep      = 2'd3
    } lseq_state_e;

    // One spare bit holds acc + src_lines before the subtract-back loop runs.
    function automatic int unsigned acc_width(int unsigned line_w);
        return line_w + 1;
    endfunction

endpackage

// File: rtl/dc_lseq_credit.sv
// Pixel FIFO credit tracker for the line sequencer.
// Tracks pixels requested but not yet written (inflight) and reports whether
// the FIFO has room for one more line.
//   clk, nrst        : clock, async active-low reset
//   en               : clock enable, state holds when low
//   fifo_level       : current FIFO occupancy in pixels
//   pixels_per_line  : size of one line request
//   line_accepted    : a line request handshake completes this cycle
//   pixel_fifo_en    : one pixel written into the FIFO this cycle
//   space_ok         : free space >= pixels_per_line
module dc_lseq_credit #(
    parameter int unsigned FIFO_LEVEL_WIDTH      = 10,
    parameter int unsigned PIXELS_PER_LINE_WIDTH = 8,
    parameter int unsigned FIFO_DEPTH            = 512
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             en,
    input  logic [FIFO_LEVEL_WIDTH-1:0]      fifo_level,
    input  logic [PIXELS_PER_LINE_WIDTH-1:0] pixels_per_line,
    input  logic                             line_accepted,
    input  logic                             pixel_fifo_en,
    output logic                             space_ok
);

    // Two extra bits keep depth - level - inflight exact and let the MSB act as sign.
    localparam int unsigned CW = ((FIFO_LEVEL_WIDTH > PIXELS_PER_LINE_WIDTH) ?
                                  FIFO_LEVEL_WIDTH : PIXELS_PER_LINE_WIDTH) + 2;
    localparam logic [CW-1:0] InflightMax = (CW'(1) << FIFO_LEVEL_WIDTH) - CW'(1);

    logic [FIFO_LEVEL_WIDTH-1:0] inflight_q, inflight_d;
    logic [CW-1:0]               free_space;
    logic [CW-1:0]               sum;
    logic [CW-1:0]               sum_dec;

    always_comb begin
        free_space = CW'(FIFO_DEPTH) - CW'(fifo_level) - CW'(inflight_q);
        // A negative free count means no space at all.
        space_ok   = !free_space[CW-1] && (free_space >= CW'(pixels_per_line));

        // Add and pixel decrement in the same cycle combine as +ppl-1, floored at 0.
        sum        = CW'(inflight_q) + (line_accepted ? CW'(pixels_per_line) : '0);
        sum_dec    = (pixel_fifo_en && (sum != '0)) ? (sum - CW'(1)) : sum;

        inflight_d = inflight_q;
        if (en) begin
            inflight_d = (sum_dec > InflightMax) ? InflightMax[FIFO_LEVEL_WIDTH-1:0]
                                                 : sum_dec[FIFO_LEVEL_WIDTH-1:0];
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            inflight_q <= '0;
        end else begin
            inflight_q <= inflight_d;
        end
    end

endmodule

// File: rtl/dc_line_sequencer.sv
// Line request sequencer: issues one line request per output video line,
// mapping output lines to source lines with an integer DDA and throttling
// against pixel FIFO free space.
//   clk, nrst             : clock, async active-low reset
//   en                    : clock enable
//   frame_start           : start pulse; cfg_* sampled on an accepted start
//   cfg_frame_addr/pixels_per_line/src_lines/dst_lines : frame configuration
//   fifo_level, pixel_fifo_en : pixel FIFO occupancy and write strobe
//   frame_addr, pixels_per_line, line_number, line_data_valid/ready : request
//   frame_done            : last line handshake of a frame
//   cfg_error             : start rejected (zero src or dst lines)
// Optional: DC_LSEQ_VFLIP_EN adds input vflip (sampled at start) which
// requests source lines bottom-up.
module dc_line_sequencer
    import dc_lseq_pkg::*;
#(
    parameter int unsigned AXI_ARADDR_WIDTH      = 32,
    parameter int unsigned PIXELS_PER_LINE_WIDTH = 8,
    parameter int unsigned LINE_NUMBER_WIDTH     = 8,
    parameter int unsigned FIFO_LEVEL_WIDTH      = 10,
    parameter int unsigned FIFO_DEPTH            = 512
) (
    input  logic                             clk,
    input  logic                             nrst,
    input  logic                             en,
    input  logic                             frame_start,
    input  logic [AXI_ARADDR_WIDTH-1:0]      cfg_frame_addr,
    input  logic [PIXELS_PER_LINE_WIDTH-1:0] cfg_pixels_per_line,
    input  logic [LINE_NUMBER_WIDTH-1:0]     cfg_src_lines,
    input  logic [LINE_NUMBER_WIDTH-1:0]     cfg_dst_lines,
    input  logic [FIFO_LEVEL_WIDTH-1:0]      fifo_level,
    input  logic                             pixel_fifo_en,
    output logic [AXI_ARADDR_WIDTH-1:0]      frame_addr,
    output logic [PIXELS_PER_LINE_WIDTH-1:0] pixels_per_line,
    output logic [LINE_NUMBER_WIDTH-1:0]     line_number,
    output logic                             line_data_valid,
    input  logic                             line_data_ready,
`ifdef DC_LSEQ_VFLIP_EN
    input  logic                             vflip,
`endif
    output logic                             frame_done,
    output logic                             cfg_error
);

    localparam int unsigned W  = LINE_NUMBER_WIDTH;
    localparam int unsigned AW = acc_width(LINE_NUMBER_WIDTH);

    lseq_state_e                      state_q, state_d;
    logic [AXI_ARADDR_WIDTH-1:0]      addr_q, addr_d;
    logic [PIXELS_PER_LINE_WIDTH-1:0] ppl_q, ppl_d;
    logic [W-1:0]                     src_lines_q, src_lines_d;
    logic [W-1:0]                     dst_lines_q, dst_lines_d;
    logic [W-1:0]                     src_idx_q, src_idx_d;
    logic [W-1:0]                     out_idx_q, out_idx_d;
    logic [AW-1:0]                    acc_q, acc_d;
    logic                             pend_q, pend_d;
`ifdef DC_LSEQ_VFLIP_EN
    logic                             vflip_q, vflip_d;
`endif

    logic hs;
    logic cfg_ok;
    logic start_req;
    logic space_ok;

    dc_lseq_credit #(
        .FIFO_LEVEL_WIDTH      (FIFO_LEVEL_WIDTH),
        .PIXELS_PER_LINE_WIDTH (PIXELS_PER_LINE_WIDTH),
        .FIFO_DEPTH            (FIFO_DEPTH)
    ) u_credit (
        .clk             (clk),
        .nrst            (nrst),
        .en              (en),
        .fifo_level      (fifo_level),
        .pixels_per_line (ppl_q),
        .line_accepted   (hs),
        .pixel_fifo_en   (pixel_fifo_en),
        .space_ok        (space_ok)
    );

    always_comb begin
        state_d     = state_q;
        addr_d      = addr_q;
        ppl_d       = ppl_q;
        src_lines_d = src_lines_q;
        dst_lines_d = dst_lines_q;
        src_idx_d   = src_idx_q;
        out_idx_d   = out_idx_q;
        acc_d       = acc_q;
        pend_d      = pend_q;
`ifdef DC_LSEQ_VFLIP_EN
        vflip_d     = vflip_q;
`endif
        frame_done  = 1'b0;
        cfg_error   = 1'b0;
        start_req   = 1'b0;
        cfg_ok      = (cfg_src_lines != '0) && (cfg_dst_lines != '0);
        hs          = en && (state_q == StRequest) && line_data_ready;

        if (en) begin
            unique case (state_q)
                StIdle: ;
                StWaitSpace: begin
                    if (space_ok) state_d = StRequest;
                end
                StRequest: begin
                    // A start during a pending request is held until the handshake.
                    if (frame_start) pend_d = 1'b1;
                    if (line_data_ready) begin
                        pend_d    = 1'b0;
                        start_req = pend_q || frame_start;
                        if (out_idx_q == dst_lines_q - W'(1)) begin
                            frame_done = 1'b1;
                            state_d    = StIdle;
                        end else begin
                            out_idx_d = out_idx_q + W'(1);
                            acc_d     = acc_q + AW'(src_lines_q);
                            state_d   = StStep;
                        end
                    end
                end
                StStep: begin
                    if (acc_q >= AW'(dst_lines_q)) begin
                        acc_d = acc_q - AW'(dst_lines_q);
                        if (src_idx_q != src_lines_q - W'(1)) src_idx_d = src_idx_q + W'(1);
                    end else begin
                        state_d = StWaitSpace;
                    end
                end
                default: state_d = StIdle;
            endcase

            if (state_q != StRequest) start_req = frame_start;

            // An accepted start overrides whatever the FSM chose this cycle;
            // a rejected one leaves the current frame untouched.
            if (start_req) begin
                if (cfg_ok) begin
                    addr_d      = cfg_frame_addr;
                    ppl_d       = cfg_pixels_per_line;
                    src_lines_d = cfg_src_lines;
                    dst_lines_d = cfg_dst_lines;
`ifdef DC_LSEQ_VFLIP_EN
                    vflip_d     = vflip;
`endif
                    src_idx_d   = '0;
                    out_idx_d   = '0;
                    acc_d       = '0;
                    frame_done  = 1'b0;
                    state_d     = StWaitSpace;
                end else begin
                    cfg_error   = 1'b1;
                end
            end
        end
    end

    always_ff @(posedge clk or negedge nrst) begin
        if (!nrst) begin
            state_q     <= StIdle;
            addr_q      <= '0;
            ppl_q       <= '0;
            src_lines_q <= '0;
            dst_lines_q <= '0;
            src_idx_q   <= '0;
            out_idx_q   <= '0;
            acc_q       <= '0;
            pend_q      <= 1'b0;
`ifdef DC_LSEQ_VFLIP_EN
            vflip_q     <= 1'b0;
`endif
        end else begin
            state_q     <= state_d;
            addr_q      <= addr_d;
            ppl_q       <= ppl_d;
            src_lines_q <= src_lines_d;
            dst_lines_q <= dst_lines_d;
            src_idx_q   <= src_idx_d;
            out_idx_q   <= out_idx_d;
            acc_q       <= acc_d;
            pend_q      <= pend_d;
`ifdef DC_LSEQ_VFLIP_EN
            vflip_q     <= vflip_d;
`endif
        end
    end

    // Valid is decoded from state so an asynchronous reset drops it at once.
    assign line_data_valid = (state_q == StRequest);
    assign frame_addr      = addr_q;
    assign pixels_per_line = ppl_q;
`ifdef DC_LSEQ_VFLIP_EN
    assign line_number     = vflip_q ? (src_lines_q - W'(1) - src_idx_q) : src_idx_q;
`else
    assign line_number     = src_idx_q;
`endif

endmodule

// File: tb/tb_dc_line_sequencer.sv
// Self-checking bench for dc_line_sequencer. Expected line numbers come from
// floor(k * src / dst) (mirrored when vflip is set). Build with
// +define+DC_LSEQ_VFLIP_EN to also exercise the vflip port.
module tb_dc_line_sequencer;

    localparam int AW = 32;
    localparam int PW = 8;
    localparam int LW = 8;
    localparam int FW = 10;

    logic          clk = 1'b0;
    logic          nrst;
    logic          en;
    logic          frame_start;
    logic [AW-1:0] cfg_frame_addr;
    logic [PW-1:0] cfg_pixels_per_line;
    logic [LW-1:0] cfg_src_lines;
    logic [LW-1:0] cfg_dst_lines;
    logic [FW-1:0] fifo_level;
    logic          pixel_fifo_en;
    logic [AW-1:0] frame_addr;
    logic [PW-1:0] pixels_per_line;
    logic [LW-1:0] line_number;
    logic          line_data_valid;
    logic          line_data_ready;
    logic          frame_done;
    logic          cfg_error;
`ifdef DC_LSEQ_VFLIP_EN
    logic          vflip;
`endif

    logic ready_mode;
    logic ready_fix;
    logic ready_rnd = 1'b1;
    assign line_data_ready = ready_mode ? ready_rnd : ready_fix;

    int checks   = 0;
    int failures = 0;
    int done_cnt  = 0;
    int err_cnt   = 0;
    int valid_cnt = 0;
    logic [LW-1:0] hs_line[$];
    logic [AW-1:0] hs_addr[$];
    logic [PW-1:0] hs_ppl[$];

    dc_line_sequencer u_dut (
        .clk                 (clk),
        .nrst                (nrst),
        .en                  (en),
        .frame_start         (frame_start),
        .cfg_frame_addr      (cfg_frame_addr),
        .cfg_pixels_per_line (cfg_pixels_per_line),
        .cfg_src_lines       (cfg_src_lines),
        .cfg_dst_lines       (cfg_dst_lines),
        .fifo_level          (fifo_level),
        .pixel_fifo_en       (pixel_fifo_en),
        .frame_addr          (frame_addr),
        .pixels_per_line     (pixels_per_line),
        .line_number         (line_number),
        .line_data_valid     (line_data_valid),
        .line_data_ready     (line_data_ready),
`ifdef DC_LSEQ_VFLIP_EN
        .vflip               (vflip),
`endif
        .frame_done          (frame_done),
        .cfg_error           (cfg_error)
    );

    always #5 clk = ~clk;

    always @(posedge clk) begin
        #1;
        ready_rnd = ($urandom_range(0, 3) != 0);
    end

    // Monitor samples on the falling edge, half a cycle from the active edge.
    always @(negedge clk) begin
        if (nrst) begin
            if (line_data_valid && line_data_ready && en) begin
                hs_line.push_back(line_number);
                hs_addr.push_back(frame_addr);
                hs_ppl.push_back(pixels_per_line);
            end
            if (frame_done) done_cnt++;
            if (cfg_error) err_cnt++;
            if (line_data_valid) valid_cnt++;
        end
    end

    function automatic logic [LW-1:0] exp_line(int k, int src, int dst, bit vf);
        int s;
        s = (k * src) / dst;
        if (s > src - 1) s = src - 1;
        if (vf) s = src - 1 - s;
        return LW'(s);
    endfunction

    task automatic tick(int n = 1);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic clear_mon();
        hs_line.delete();
        hs_addr.delete();
        hs_ppl.delete();
    endtask

    task automatic apply_reset();
        nrst = 1'b0;
        tick(2);
        nrst = 1'b1;
        tick();
    endtask

    task automatic start_frame(int src, int dst, int ppl, logic [AW-1:0] addr, bit vf);
        cfg_src_lines       = LW'(src);
        cfg_dst_lines       = LW'(dst);
        cfg_pixels_per_line = PW'(ppl);
        cfg_frame_addr      = addr;
`ifdef DC_LSEQ_VFLIP_EN
        vflip = vf;
`endif
        frame_start = 1'b1;
        tick();
        frame_start = 1'b0;
    endtask

    task automatic wait_done(int base, int budget, string name);
        int n;
        n = 0;
        while (done_cnt == base && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (done_cnt == base) begin
            failures++;
            $display("FAIL %s: frame_done count %0d after %0d cycles, required %0d",
                     name, done_cnt, n, base + 1);
        end
    endtask

    task automatic wait_valid(int budget, string name);
        int n;
        n = 0;
        while (!line_data_valid && n < budget) begin
            tick();
            n++;
        end
        checks++;
        if (line_data_valid !== 1'b1) begin
            failures++;
            $display("FAIL %s: valid=%b after %0d cycles, required 1", name, line_data_valid, n);
        end
    endtask

    task automatic check_frame(string name, int src, int dst, logic [AW-1:0] addr,
                               logic [PW-1:0] ppl, bit vf);
        logic [LW-1:0] el;
        checks++;
        if (hs_line.size() != dst) begin
            failures++;
            $display("FAIL %s count: got %0d handshakes, required %0d", name, hs_line.size(), dst);
        end
        for (int k = 0; k < hs_line.size() && k < dst; k++) begin
            el = exp_line(k, src, dst, vf);
            checks++;
            if (hs_line[k] !== el || hs_addr[k] !== addr || hs_ppl[k] !== ppl) begin
                failures++;
                $display("FAIL %s line %0d: got line=%0d addr=%h ppl=%0d, required line=%0d addr=%h ppl=%0d",
                         name, k, hs_line[k], hs_addr[k], hs_ppl[k], el, addr, ppl);
            end
        end
    endtask

    task automatic run_frame(string name, int src, int dst, int ppl, bit vf);
        logic [AW-1:0] addr;
        int base;
        addr = $urandom;
        clear_mon();
        base = done_cnt;
        start_frame(src, dst, ppl, addr, vf);
        wait_done(base, 4000, name);
        tick(3);
        check_frame(name, src, dst, addr, PW'(ppl), vf);
        checks++;
        if (done_cnt !== base + 1) begin
            failures++;
            $display("FAIL %s done pulses: got %0d, required 1", name, done_cnt - base);
        end
    endtask

    task automatic test_reset();
        checks++;
        if (line_data_valid !== 1'b0) begin
            failures++; $display("FAIL reset valid: got %b required 0", line_data_valid);
        end
        checks++;
        if (frame_done !== 1'b0 || cfg_error !== 1'b0) begin
            failures++; $display("FAIL reset pulses: got done=%b err=%b required 0 0", frame_done, cfg_error);
        end
        checks++;
        if (line_number !== '0 || frame_addr !== '0 || pixels_per_line !== '0) begin
            failures++;
            $display("FAIL reset payload: got line=%0d addr=%h ppl=%0d required 0 0 0",
                     line_number, frame_addr, pixels_per_line);
        end
    endtask

    task automatic test_ratios();
        ready_mode = 1'b0; ready_fix = 1'b1; pixel_fifo_en = 1'b1; fifo_level = '0;
        run_frame("ratio_4_4", 4, 4, 16, 1'b0);
        run_frame("ratio_2_4", 2, 4, 16, 1'b0);
        run_frame("ratio_4_2", 4, 2, 16, 1'b0);
        run_frame("ratio_1_1", 1, 1, 8, 1'b0);
        run_frame("ratio_3_7", 3, 7, 5, 1'b0);
    endtask

    task automatic test_dda_random();
        ready_mode = 1'b1; pixel_fifo_en = 1'b1; fifo_level = '0;
        for (int i = 0; i < 8; i++) begin
            run_frame("random", int'($urandom_range(1, 12)), int'($urandom_range(1, 12)),
                      int'($urandom_range(1, 40)), 1'b0);
        end
        ready_mode = 1'b0; ready_fix = 1'b1;
    endtask

    // Level 480 on a 512-pixel FIFO leaves 32 pixels of room: two 16-pixel lines.
    task automatic test_throttle();
        logic [AW-1:0] addr;
        int base;
        int n;
        apply_reset();
        ready_mode = 1'b0; ready_fix = 1'b1; pixel_fifo_en = 1'b0; fifo_level = FW'(480);
        addr = $urandom;
        clear_mon();
        base = done_cnt;
        start_frame(4, 4, 16, addr, 1'b0);
        tick(40);
        checks++;
        if (hs_line.size() != 2 || line_data_valid !== 1'b0) begin
            failures++;
            $display("FAIL throttle_stall: got %0d requests valid=%b, required 2 valid=0",
                     hs_line.size(), line_data_valid);
        end
        pixel_fifo_en = 1'b1; tick(15); pixel_fifo_en = 1'b0;
        tick(10);
        checks++;
        if (hs_line.size() != 2) begin
            failures++;
            $display("FAIL throttle_15px: got %0d requests, required 2", hs_line.size());
        end
        pixel_fifo_en = 1'b1; tick(); pixel_fifo_en = 1'b0;
        n = 0;
        while (hs_line.size() < 3 && n < 10) begin tick(); n++; end
        checks++;
        if (hs_line.size() != 3) begin
            failures++;
            $display("FAIL throttle_16px: got %0d requests, required 3", hs_line.size());
        end
        pixel_fifo_en = 1'b1;
        wait_done(base, 200, "throttle_done");
        tick(2);
        check_frame("throttle", 4, 4, addr, PW'(16), 1'b0);
        fifo_level = '0;
    endtask

    task automatic test_stall_restart();
        logic [AW-1:0] addr_a, addr_b;
        logic [AW-1:0] exp_a[4];
        logic [LW-1:0] cap_line;
        logic [LW-1:0] exp_l[4];
        int base;
        addr_a = $urandom;
        addr_b = addr_a ^ 32'h00F0_0F00;
        exp_l = '{8'd0, 8'd1, 8'd0, 8'd1};
        exp_a = '{addr_a, addr_a, addr_b, addr_b};
        ready_mode = 1'b0; ready_fix = 1'b0; pixel_fifo_en = 1'b1; fifo_level = '0;
        clear_mon();
        base = done_cnt;
        start_frame(2, 2, 16, addr_a, 1'b0);
        wait_valid(20, "stall_first");
        ready_fix = 1'b1; tick(); ready_fix = 1'b0;
        wait_valid(20, "stall_last");
        cap_line = line_number;
        for (int i = 0; i < 10; i++) begin
            frame_start = (i == 4);
            if (i == 4) cfg_frame_addr = addr_b;
            tick();
            checks++;
            if (line_data_valid !== 1'b1 || line_number !== cap_line || frame_addr !== addr_a) begin
                failures++;
                $display("FAIL stall_stable cycle %0d: got valid=%b line=%0d addr=%h, required 1 %0d %h",
                         i, line_data_valid, line_number, frame_addr, cap_line, addr_a);
            end
        end
        frame_start = 1'b0;
        ready_fix = 1'b1;
        wait_done(base, 100, "restart_done");
        tick(3);
        checks++;
        if (done_cnt !== base + 1 || hs_line.size() != 4) begin
            failures++;
            $display("FAIL restart_counts: got done=%0d hs=%0d, required done=1 hs=4",
                     done_cnt - base, hs_line.size());
        end
        for (int k = 0; k < 4 && k < hs_line.size(); k++) begin
            checks++;
            if (hs_line[k] !== exp_l[k] || hs_addr[k] !== exp_a[k]) begin
                failures++;
                $display("FAIL restart_seq %0d: got line=%0d addr=%h, required line=%0d addr=%h",
                         k, hs_line[k], hs_addr[k], exp_l[k], exp_a[k]);
            end
        end
    endtask

    task automatic test_cfg_error();
        int base_err;
        int base_valid;
        ready_fix = 1'b1;
        base_err = err_cnt;
        base_valid = valid_cnt;
        start_frame(3, 0, 16, 32'h1000, 1'b0);
        tick(10);
        checks++;
        if (err_cnt !== base_err + 1 || valid_cnt !== base_valid) begin
            failures++;
            $display("FAIL cfg_dst_zero: got errors=%0d valid_cycles=%0d, required 1 0",
                     err_cnt - base_err, valid_cnt - base_valid);
        end
        start_frame(0, 3, 16, 32'h2000, 1'b0);
        tick(10);
        checks++;
        if (err_cnt !== base_err + 2 || valid_cnt !== base_valid) begin
            failures++;
            $display("FAIL cfg_src_zero: got errors=%0d valid_cycles=%0d, required 2 0",
                     err_cnt - base_err, valid_cnt - base_valid);
        end
    endtask

    task automatic test_en_hold();
        int base_valid;
        int base_err;
        base_valid = valid_cnt;
        base_err = err_cnt;
        en = 1'b0;
        start_frame(2, 2, 16, 32'h3000, 1'b0);
        start_frame(2, 0, 16, 32'h3000, 1'b0);
        tick(10);
        checks++;
        if (valid_cnt !== base_valid || err_cnt !== base_err) begin
            failures++;
            $display("FAIL en_hold: got valid_cycles=%0d errors=%0d, required 0 0",
                     valid_cnt - base_valid, err_cnt - base_err);
        end
        en = 1'b1;
        tick();
    endtask

`ifdef DC_LSEQ_VFLIP_EN
    task automatic test_vflip();
        ready_mode = 1'b0; ready_fix = 1'b1; pixel_fifo_en = 1'b1;
        run_frame("vflip_3_3", 3, 3, 16, 1'b1);
        for (int i = 0; i < 3; i++) begin
            run_frame("vflip_rand", int'($urandom_range(1, 9)), int'($urandom_range(1, 9)),
                      int'($urandom_range(1, 30)), 1'b1);
        end
        vflip = 1'b0;
    endtask
`endif

    task automatic test_reset_mid_request();
        ready_fix = 1'b0;
        start_frame(3, 3, 16, 32'hABCD_0000, 1'b0);
        wait_valid(20, "reset_mid_wait");
        #2;
        nrst = 1'b0;
        #1;
        checks++;
        if (line_data_valid !== 1'b0 || frame_addr !== '0) begin
            failures++;
            $display("FAIL reset_mid_request: got valid=%b addr=%h, required 0 0",
                     line_data_valid, frame_addr);
        end
        tick();
        nrst = 1'b1;
        tick();
    endtask

    initial begin
        nrst = 1'b0; en = 1'b1; frame_start = 1'b0;
        cfg_frame_addr = '0; cfg_pixels_per_line = '0; cfg_src_lines = '0; cfg_dst_lines = '0;
        fifo_level = '0; pixel_fifo_en = 1'b0; ready_mode = 1'b0; ready_fix = 1'b0;
`ifdef DC_LSEQ_VFLIP_EN
        vflip = 1'b0;
`endif
        repeat (3) @(posedge clk);
        #1;
        test_reset();
        nrst = 1'b1;
        tick();
        test_reset();
        test_ratios();
        test_dda_random();
        test_throttle();
        test_stall_restart();
        test_cfg_error();
        test_en_hold();
`ifdef DC_LSEQ_VFLIP_EN
        test_vflip();
`endif
        test_reset_mid_request();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
